// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing a byte-wide RAM port between fetch and load/store
//
// Purpose: serialises 1/2/4-byte instruction-fetch and load/store transfers onto a single
//          byte-wide RAM port, assembling little-endian words on reads and
//          disassembling them on writes.
// Optional feature: define MEM_ARBITER_IO_STALL_EN to hold stores at or above IO_ADDR
//                   while io_buffer_full is high.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable), clear (flush)
//   if_req/if_addr -> if_done/if_data                     fetch side, 4-byte reads
//   lsb_req/lsb_we/lsb_len/lsb_addr/lsb_wdata -> lsb_done/lsb_rdata   load/store side
//   mem_din <- RAM read byte; mem_dout/mem_a/mem_wr -> RAM
//   io_buffer_full                                        UART FIFO full
module mem_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = 'h30000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [1:0]        lsb_len,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_lsb;   // 1: LSB was granted last, so IF wins the next tie
  logic              r_owner_lsb;  // owner of the current read
  logic [2:0]        r_cnt;        // edges since the grant edge
  logic [2:0]        r_len;        // transfer length in bytes (1/2/4)
  logic [31:0]       r_buf;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_if_done, r_lsb_done;
  logic [31:0]       r_if_data, r_lsb_rdata;

  logic              w_if_ok, w_lsb_ok, w_grant_if, w_grant_lsb;
  logic              w_io_block, w_io_hold;
  logic [2:0]        w_lsb_n;
  logic [1:0]        w_byte_idx;
  logic [31:0]       w_asm;

`ifdef MEM_ARBITER_IO_STALL_EN
  logic r_io;  // current store targets the I/O region
  assign w_io_block = lsb_we && (lsb_addr >= IO_ADDR) && io_buffer_full;
  assign w_io_hold  = r_io && io_buffer_full;
`else
  logic w_unused_io;
  assign w_io_block  = 1'b0;
  assign w_io_hold   = 1'b0;
  assign w_unused_io = io_buffer_full ^ (lsb_addr >= IO_ADDR);
`endif

  always_comb begin
    w_lsb_n = 3'd4;
    case (lsb_len)
      2'b00:   w_lsb_n = 3'd1;
      2'b01:   w_lsb_n = 3'd2;
      default: w_lsb_n = 3'd4;
    endcase
  end

  // A flush suppresses read grants only; stores are never speculative.
  assign w_if_ok  = if_req && !clear;
  assign w_lsb_ok = lsb_req && (lsb_we ? !w_io_block : !clear);

  // RAM has one cycle of latency: at edge k (k >= 2) mem_din carries byte k-2.
  assign w_byte_idx = r_cnt[1:0] - 2'd2;
  assign w_asm      = r_buf | ({24'd0, mem_din} << {w_byte_idx, 3'b000});

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_lsb = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_if_ok && (!w_lsb_ok || r_last_lsb)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_READ;
        end else if (w_lsb_ok) begin
          w_grant_lsb = 1'b1;
          w_state_nxt = lsb_we ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (clear || (r_cnt == r_len + 3'd1)) w_state_nxt = S_IDLE;
      end
      S_WRITE: begin
        if (!w_io_hold && (r_cnt == r_len)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_lsb  <= 1'b1;
      r_owner_lsb <= 1'b0;
      r_cnt       <= 3'd0;
      r_len       <= 3'd0;
      r_buf       <= 32'd0;
      r_wdata     <= 32'd0;
      r_mem_a     <= '0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_lsb_rdata <= 32'd0;
`ifdef MEM_ARBITER_IO_STALL_EN
      r_io        <= 1'b0;
`endif
    end else if (rdy_in) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            r_last_lsb  <= 1'b0;
            r_owner_lsb <= 1'b0;
            r_len       <= 3'd4;
            r_cnt       <= 3'd1;
            r_buf       <= 32'd0;
            r_mem_a     <= if_addr;
          end else if (w_grant_lsb) begin
            r_last_lsb  <= 1'b1;
            r_owner_lsb <= 1'b1;
            r_len       <= w_lsb_n;
            r_cnt       <= 3'd1;
            r_buf       <= 32'd0;
            r_wdata     <= lsb_wdata;
            r_mem_a     <= lsb_addr;
            r_mem_dout  <= lsb_wdata[7:0];
            r_mem_wr    <= lsb_we;
`ifdef MEM_ARBITER_IO_STALL_EN
            r_io        <= lsb_we && (lsb_addr >= IO_ADDR);
`endif
          end
        end
        S_READ: begin
          if (!clear) begin
            if (r_cnt < r_len) r_mem_a <= r_mem_a + ADDR_W'(1);
            if (r_cnt >= 3'd2) r_buf <= w_asm;
            if (r_cnt == r_len + 3'd1) begin
              if (r_owner_lsb) begin
                r_lsb_done  <= 1'b1;
                r_lsb_rdata <= w_asm;
              end else begin
                r_if_done <= 1'b1;
                r_if_data <= w_asm;
              end
            end
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          if (!w_io_hold) begin
            if (r_cnt == r_len) begin
              r_mem_wr   <= 1'b0;
              r_lsb_done <= 1'b1;
            end else begin
              r_mem_a    <= r_mem_a + ADDR_W'(1);
              r_mem_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
              r_cnt      <= r_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign if_data   = r_if_data;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;
  assign mem_a     = r_mem_a;
  assign mem_dout  = r_mem_dout;
  // Strobe is gated so a frozen or I/O-held cycle never repeats a byte write.
  assign mem_wr    = r_mem_wr && rdy_in && !w_io_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a byte-wide 1-cycle RAM model
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        lsb_req, lsb_we, lsb_done;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.ADDR_W(32), .IO_ADDR(32'h30000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // RAM model: 4 KiB aliased, one cycle read latency, shares the global enable.
  logic [7:0] ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h010] = 8'h11; ram[12'h011] = 8'h22; ram[12'h012] = 8'h33; ram[12'h013] = 8'h44;
    ram[12'h040] = 8'hA1; ram[12'h041] = 8'hB2; ram[12'h042] = 8'hC3; ram[12'h043] = 8'hD4;
    mem_din = 8'h00;
    forever begin
      @(posedge clk_in);
      if (rdy_in === 1'b1) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr === 1'b1) ram[mem_a[11:0]] = mem_dout;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall_at;
    int          stall_len;
    logic [31:0] frz_a;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wrs;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ram(input string name, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata);
    int n;
    logic [31:0] a, w;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    w = wdata;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      check($sformatf("%s ram byte%0d", name, i), {24'd0, ram[a[11:0]]}, {24'd0, w[7:0]});
      w = w >> 8;
    end
  endtask

  // Cycle c is the falling edge after the c-th rising edge, the grant edge being the first.
  task automatic run_lsb(input logic we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall_at, input int stall_len,
                         input logic [31:0] frz_a, output logic [31:0] rdata,
                         output int lat, output int wrs, output logic frz_ok);
    lsb_we = we; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata; lsb_req = 1'b1;
    rdata = 32'd0; lat = -1; wrs = 0; frz_ok = 1'b1;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (stall_len > 0 && c == stall_at) begin
        rdy_in = 1'b0; #1;
        if (mem_wr !== 1'b0 || mem_a !== frz_a) frz_ok = 1'b0;
      end else if (stall_len > 0 && c > stall_at && c < stall_at + stall_len) begin
        if (mem_wr !== 1'b0 || mem_a !== frz_a) frz_ok = 1'b0;
      end else if (stall_len > 0 && c == stall_at + stall_len) begin
        if (mem_a !== frz_a) frz_ok = 1'b0;
        rdy_in = 1'b1; #1;
      end
      if (mem_wr === 1'b1) wrs++;
      if (lsb_done === 1'b1) begin
        lat = c;
        rdata = lsb_rdata;
      end
    end
    lsb_req = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] addr, output logic [31:0] data, output int lat,
                        output logic [127:0] trace);
    if_addr = addr; if_req = 1'b1; data = 32'd0; lat = -1; trace = '0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (c <= 4) trace = {mem_a, trace[127:32]};
      if (if_done === 1'b1) begin
        lat = c;
        data = if_data;
      end
    end
    if_req = 1'b0;
  endtask

  logic [31:0]  rd;
  logic [127:0] tr;
  logic         frz;
  int           lat, wrs, t_if, t_lsb, nd;
  logic [31:0]  a1;

  initial begin
    //                  we    len    addr          wdata         stl stln frz_a      exp_rdata     lat wrs
    vecs[0]  = '{1'b1, 2'b10, 32'h200,      32'hDEADBEEF, 0, 0, 32'h0,     32'h0,        5, 4};
    vecs[1]  = '{1'b0, 2'b01, 32'h010,      32'h0,        0, 0, 32'h0,     32'h00002211, 4, 0};
    vecs[2]  = '{1'b0, 2'b00, 32'h013,      32'h0,        0, 0, 32'h0,     32'h00000044, 3, 0};
    vecs[3]  = '{1'b0, 2'b10, 32'h040,      32'h0,        0, 0, 32'h0,     32'hD4C3B2A1, 6, 0};
    vecs[4]  = '{1'b1, 2'b00, 32'h041,      32'h12345677, 0, 0, 32'h0,     32'h0,        2, 1};
    vecs[5]  = '{1'b1, 2'b01, 32'h300,      32'hAAAA5566, 0, 0, 32'h0,     32'h0,        3, 2};
    vecs[6]  = '{1'b0, 2'b10, 32'h040,      32'h0,        0, 0, 32'h0,     32'hD4C377A1, 6, 0};
    vecs[7]  = '{1'b0, 2'b10, 32'h200,      32'h0,        0, 0, 32'h0,     32'hDEADBEEF, 6, 0};
    vecs[8]  = '{1'b0, 2'b11, 32'h300,      32'h0,        0, 0, 32'h0,     32'h00005566, 6, 0};
    vecs[9]  = '{1'b0, 2'b10, 32'h040,      32'h0,        2, 3, 32'h41,    32'hD4C377A1, 9, 0};
    vecs[10] = '{1'b1, 2'b10, 32'h400,      32'h01020304, 1, 3, 32'h400,   32'h0,        8, 4};
    vecs[11] = '{1'b1, 2'b10, 32'hFFFFFFFE, 32'h0A0B0C0D, 0, 0, 32'h0,     32'h0,        5, 4};
    vecs[12] = '{1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        0, 0, 32'h0,     32'h0A0B0C0D, 6, 0};
    vecs[13] = '{1'b0, 2'b10, 32'h400,      32'h0,        0, 0, 32'h0,     32'h01020304, 6, 0};
    vecs[14] = '{1'b0, 2'b01, 32'h202,      32'h0,        0, 0, 32'h0,     32'h0000DEAD, 4, 0};

    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_len = 2'b00; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;

    check("reset if_done",   {31'd0, if_done},  32'd0);
    check("reset lsb_done",  {31'd0, lsb_done}, 32'd0);
    check("reset mem_wr",    {31'd0, mem_wr},   32'd0);
    check("reset mem_a",     mem_a,             32'd0);
    check("reset mem_dout",  {24'd0, mem_dout}, 32'd0);
    check("reset if_data",   if_data,           32'd0);
    check("reset lsb_rdata", lsb_rdata,         32'd0);

    // Tie straight after reset: IF first, then the half load on the next IDLE cycle.
    if_addr = 32'h100; lsb_we = 1'b0; lsb_len = 2'b01; lsb_addr = 32'h10;
    if_req = 1'b1; lsb_req = 1'b1; t_if = -1; t_lsb = -1; rd = 32'd0; a1 = 32'd0;
    for (int c = 1; c <= 40 && t_lsb < 0; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (c == 1) a1 = mem_a;
      if (if_done === 1'b1) begin t_if = c; if_req = 1'b0; end
      if (lsb_done === 1'b1) begin t_lsb = c; rd = lsb_rdata; lsb_req = 1'b0; end
    end
    if_req = 1'b0; lsb_req = 1'b0;
    check("tie first mem_a", a1, 32'h100);
    check("tie if_done cycle", t_if, 32'd6);
    check("tie lsb_done cycle", t_lsb, 32'd10);
    check("tie lsb_rdata", rd, 32'h00002211);

    // Fetch alone: address walk and one-cycle done pulse.
    run_if(32'h100, rd, lat, tr);
    check("if mem_a E0", tr[31:0],   32'h100);
    check("if mem_a E1", tr[63:32],  32'h101);
    check("if mem_a E2", tr[95:64],  32'h102);
    check("if mem_a E3", tr[127:96], 32'h103);
    check("if latency", lat, 32'd6);
    check("if data", rd, 32'h00000513);
    @(posedge clk_in); @(negedge clk_in);
    check("if_done pulse width", {31'd0, if_done}, 32'd0);

    // Flush sampled at E2 of a fetch aborts it without a done pulse.
    if_addr = 32'h100; if_req = 1'b1;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    clear = 1'b1;
    @(posedge clk_in); @(negedge clk_in);
    clear = 1'b0; if_req = 1'b0;
    check("clear mem_a held", mem_a, 32'h101);
    nd = (if_done === 1'b1) ? 1 : 0;
    repeat (8) begin
      @(posedge clk_in); @(negedge clk_in);
      if (if_done === 1'b1) nd++;
    end
    check("clear no if_done", nd, 32'd0);
    run_if(32'h100, rd, lat, tr);
    check("refetch mem_a E0", tr[31:0], 32'h100);
    check("refetch latency", lat, 32'd6);
    check("refetch data", rd, 32'h00000513);

    for (int i = 0; i < NV; i++) begin
      run_lsb(vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, vecs[i].stall_at,
              vecs[i].stall_len, vecs[i].frz_a, rd, lat, wrs, frz);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d write strobes", i), wrs, vecs[i].exp_wrs);
      if (vecs[i].we) check_ram($sformatf("v%0d", i), vecs[i].addr, vecs[i].len, vecs[i].wdata);
      else            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].stall_len > 0) check($sformatf("v%0d frozen", i), {31'd0, frz}, 32'd1);
    end

    // A store is granted and completes even with the flush held high throughout.
    clear = 1'b1;
    run_lsb(1'b1, 2'b00, 32'h50, 32'h0000005A, 0, 0, 32'h0, rd, lat, wrs, frz);
    check("clear store latency", lat, 32'd2);
    check("clear store strobes", wrs, 32'd1);
    check_ram("clear store", 32'h50, 2'b00, 32'h5A);

    // A load is not granted while the flush is high, then proceeds once it drops.
    lsb_we = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h13; lsb_req = 1'b1; nd = 0;
    repeat (3) begin
      @(posedge clk_in); @(negedge clk_in);
      if (lsb_done === 1'b1) nd++;
    end
    check("clear blocks load done", nd, 32'd0);
    check("clear blocks load mem_a", mem_a, 32'h50);
    clear = 1'b0;
    run_lsb(1'b0, 2'b00, 32'h13, 32'h0, 0, 0, 32'h0, rd, lat, wrs, frz);
    check("post-clear load latency", lat, 32'd3);
    check("post-clear load rdata", rd, 32'h00000044);

    // Byte store into the I/O region with the UART FIFO full.
    io_buffer_full = 1'b1;
`ifdef MEM_ARBITER_IO_STALL_EN
    lsb_we = 1'b1; lsb_len = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'hC3; lsb_req = 1'b1;
    nd = 0;
    repeat (4) begin
      @(posedge clk_in); @(negedge clk_in);
      if (mem_wr === 1'b1 || lsb_done === 1'b1) nd++;
    end
    check("io stall no write", nd, 32'd0);
    io_buffer_full = 1'b0;
`endif
    run_lsb(1'b1, 2'b00, 32'h30000, 32'h000000C3, 0, 0, 32'h0, rd, lat, wrs, frz);
    io_buffer_full = 1'b0;
    check("io store latency", lat, 32'd2);
    check("io store strobes", wrs, 32'd1);
    check_ram("io store", 32'h30000, 2'b00, 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
